// File: rtl/fp32_red_pkg.sv
// Shared definitions for the fp32 dot-product reducer: fp32 constants, FSM states and
// the bit-slice lane unpack shared with the multiplier's pack order.
package fp32_red_pkg;

  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_MANT_W = 23;
  localparam int unsigned FP32_BIAS   = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam logic [31:0] FP32_NINF = 32'hFF800000;

  localparam int unsigned LANES = 32;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } red_state_e;

  // Slice n carries nibble n of every lane; lane k sits at nibble position k of each slice.
  function automatic logic [31:0] fp32_lane_unpack(input logic [7:0][127:0] slices,
                                                   input logic [IDX_W-1:0] idx);
    logic [31:0] lane;
    lane = '0;
    for (int n = 0; n < 8; n++) begin
      lane[4*n +: 4] = slices[n][4*idx +: 4];
    end
    return lane;
  endfunction

endpackage

// File: rtl/fp32_add_rne.sv
// Combinational IEEE-754 binary32 adder, round-to-nearest-even, subnormals flushed to
// signed zero, canonical NaN on invalid operations.
module fp32_add_rne
  import fp32_red_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  logic                   a_s, b_s;
  logic [FP32_EXP_W-1:0]  a_e, b_e;
  logic [FP32_MANT_W-1:0] a_m, b_m;

  assign {a_s, a_e, a_m} = a_i;
  assign {b_s, b_e, b_m} = b_i;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (a_e == '1) && (a_m != '0);
  assign b_nan  = (b_e == '1) && (b_m != '0);
  assign a_inf  = (a_e == '1) && (a_m == '0);
  assign b_inf  = (b_e == '1) && (b_m == '0);
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);

  logic        x_s, y_s;
  logic [7:0]  x_e, y_e;
  logic [23:0] x_sig, y_sig;

  always_comb begin
    if ({a_e, a_m} >= {b_e, b_m}) begin
      x_s = a_s; x_e = a_e; x_sig = {1'b1, a_m};
      y_s = b_s; y_e = b_e; y_sig = {1'b1, b_m};
    end else begin
      x_s = b_s; x_e = b_e; x_sig = {1'b1, b_m};
      y_s = a_s; y_e = a_e; y_sig = {1'b1, a_m};
    end
  end

  logic [7:0]  exp_diff;
  logic [4:0]  shamt;
  logic [53:0] y_wide;
  logic [26:0] x_ext, y_ext;

  assign exp_diff = x_e - y_e;
  // Saturating at 26 still leaves the hidden bit in the sticky position.
  assign shamt    = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
  assign y_wide   = {y_sig, 3'b000, 27'd0} >> shamt;
  assign x_ext    = {x_sig, 3'b000};
  assign y_ext    = {y_wide[53:28], y_wide[27] | (|y_wide[26:0])};

  logic              eff_sub;
  logic [27:0]       raw;
  logic [26:0]       norm;
  logic [4:0]        lz;
  logic              found;
  logic signed [9:0] exp_n;
  logic              round_up;
  logic [24:0]       mant_r;

  assign eff_sub = x_s ^ y_s;

  always_comb begin
    raw   = eff_sub ? ({1'b0, x_ext} - {1'b0, y_ext}) : ({1'b0, x_ext} + {1'b0, y_ext});
    exp_n = $signed({2'b00, x_e});
    norm  = raw[26:0];
    lz    = '0;
    found = 1'b0;
    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_n = exp_n + 10'sd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found && raw[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      norm  = raw[26:0] << lz;
      exp_n = exp_n - $signed({5'b00000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      exp_n  = exp_n + 10'sd1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      sum_o = FP32_QNAN;
    end else if (a_inf) begin
      sum_o = a_s ? FP32_NINF : FP32_PINF;
    end else if (b_inf) begin
      sum_o = b_s ? FP32_NINF : FP32_PINF;
    end else if (a_zero && b_zero) begin
      sum_o = {a_s & b_s, 31'd0};
    end else if (a_zero) begin
      sum_o = b_i;
    end else if (b_zero) begin
      sum_o = a_i;
    end else if (raw == '0) begin
      sum_o = 32'd0;
    end else if (exp_n >= 10'sd255) begin
      sum_o = x_s ? FP32_NINF : FP32_PINF;
    end else if (exp_n <= 10'sd0) begin
      sum_o = {x_s, 31'd0};
    end else begin
      sum_o = {x_s, exp_n[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fp32_dot_reducer.sv
// Captures a bit-sliced set of 32 fp32 products and accumulates the masked lanes, one lane
// per cycle, into a running fp32 accumulator; publishes the accumulator on completion.
module fp32_dot_reducer
  import fp32_red_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] dr_fp16mul_d0,
  input  logic [127:0] dr_fp16mul_d1,
  input  logic [127:0] dr_fp16mul_d2,
  input  logic [127:0] dr_fp16mul_d3,
  input  logic [127:0] dr_fp16mul_d4,
  input  logic [127:0] dr_fp16mul_d5,
  input  logic [127:0] dr_fp16mul_d6,
  input  logic [127:0] dr_fp16mul_d7,
  input  logic [1:0]   cru_fp32red,
  input  logic [31:0]  cru_fp32red_mask,
  output logic [31:0]  dr_fp32red_sum,
  output logic         fp32red_busy,
  output logic         fp32red_done
);

  red_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0][127:0] cap_q, cap_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       sum_q, sum_d;
  logic              done_q, done_d;

  logic        start, acc_clear;
  logic [31:0] lane, add_res;

  assign start     = cru_fp32red[1];
  assign acc_clear = cru_fp32red[0];

  assign lane = fp32_lane_unpack(cap_q, idx_q);

  fp32_add_rne u_add (
    .a_i  (acc_q),
    .b_i  (lane),
    .sum_o(add_res)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cap_d   = {dr_fp16mul_d7, dr_fp16mul_d6, dr_fp16mul_d5, dr_fp16mul_d4,
                     dr_fp16mul_d3, dr_fp16mul_d2, dr_fp16mul_d1, dr_fp16mul_d0};
          mask_d  = cru_fp32red_mask;
          acc_d   = acc_clear ? 32'd0 : acc_q;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (mask_q[idx_q]) acc_d = add_res;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(LANES - 1)) state_d = StDone;
      end
      StDone: begin
        sum_d   = acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  assign dr_fp32red_sum = sum_q;
  assign fp32red_busy   = (state_q != StIdle);
  assign fp32red_done   = done_q;

endmodule

// File: tb/tb_fp32_dot_reducer.sv
// Table-driven bench for fp32_dot_reducer with an expected-result queue popped on done.
module tb_fp32_dot_reducer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [1:0]   cru = 2'b00;
  logic [31:0]  mask = '0;
  logic [31:0]  sum;
  logic         busy, done;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fp32_dot_reducer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dr_fp16mul_d0   (d0),
    .dr_fp16mul_d1   (d1),
    .dr_fp16mul_d2   (d2),
    .dr_fp16mul_d3   (d3),
    .dr_fp16mul_d4   (d4),
    .dr_fp16mul_d5   (d5),
    .dr_fp16mul_d6   (d6),
    .dr_fp16mul_d7   (d7),
    .cru_fp32red     (cru),
    .cru_fp32red_mask(mask),
    .dr_fp32red_sum  (sum),
    .fp32red_busy    (busy),
    .fp32red_done    (done)
  );

  typedef struct {
    string       name;
    logic [31:0] fill;
    logic [31:0] l0;
    logic [31:0] l1;
    logic [31:0] msk;
    logic        clr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Lane k nibble n goes to slice n at nibble position k.
  task automatic set_data(input logic [31:0] fill, input logic [31:0] l0, input logic [31:0] l1);
    logic [31:0]  lanes[32];
    logic [127:0] s[8];
    for (int k = 0; k < 32; k++) lanes[k] = fill;
    lanes[0] = l0;
    lanes[1] = l1;
    for (int n = 0; n < 8; n++) begin
      s[n] = '0;
      for (int k = 0; k < 32; k++) s[n][4*k +: 4] = lanes[k][4*n +: 4];
    end
    {d0, d1, d2, d3, d4, d5, d6, d7} = {s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
  endtask

  // Starts one run; optionally re-pulses start with other data at cycle inject_at.
  task automatic run_vec(input vec_t v, input int inject_at);
    int          lat;
    logic        busy_ok;
    logic [31:0] e;
    @(negedge clk);
    set_data(v.fill, v.l0, v.l1);
    mask = v.msk;
    cru  = {1'b1, v.clr};
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1 cru = 2'b00;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
      else if (!busy) busy_ok = 1'b0;
      if (k == inject_at) begin
        set_data(32'h40000000, 32'h40000000, 32'h40000000);
        mask = 32'hFFFF_FFFF;
        cru  = 2'b11;
      end else if (k == inject_at + 1) begin
        cru = 2'b00;
      end
    end
    cru = 2'b00;
    check32({v.name, "_latency"}, 32'(lat), 32'd33);
    if (lat != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check32({v.name, "_sum"}, sum, e);
      check32({v.name, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
      check32({v.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check32({v.name, "_done_pulse"}, {31'd0, done}, 32'd0);
      check32({v.name, "_sum_hold"}, sum, v.exp);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    tbl[0]  = '{"ones_clr",   32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 1'b1,
                32'h42000000};
    tbl[1]  = '{"ones_keep",  32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 1'b0,
                32'h42800000};
    tbl[2]  = '{"mask_zero",  32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b1,
                32'h00000000};
    tbl[3]  = '{"cancel",     32'h0,        32'h3F800000, 32'hBF800000, 32'h00000003, 1'b1,
                32'h00000000};
    tbl[4]  = '{"inf_minus",  32'h0,        32'h7F800000, 32'hFF800000, 32'h00000003, 1'b1,
                32'h7FC00000};
    tbl[5]  = '{"overflow",   32'h0,        32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000003, 1'b1,
                32'h7F800000};
    tbl[6]  = '{"tie_even",   32'h0,        32'h4B800000, 32'h3F800000, 32'h00000003, 1'b1,
                32'h4B800000};
    tbl[7]  = '{"round_up",   32'h0,        32'h4B800000, 32'h40400000, 32'h00000003, 1'b1,
                32'h4B800002};
    tbl[8]  = '{"inf_fin",    32'h0,        32'h7F800000, 32'h3F800000, 32'h00000003, 1'b1,
                32'h7F800000};
    tbl[9]  = '{"inf_sticky", 32'h0,        32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0,
                32'h7F800000};
    tbl[10] = '{"subn_flush", 32'h0,        32'h00000001, 32'h3F800000, 32'h00000003, 1'b1,
                32'h3F800000};

    set_data(32'h0, 32'h0, 32'h0);
    #1;
    check32("reset_sum", sum, 32'h0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], -10);

    // Lane selection by mask: only lane1 (0.5) contributes.
    run_vec('{"mask_sel", 32'h0, 32'h40000000, 32'h3F000000, 32'h00000002, 1'b1, 32'h3F000000},
            -10);

    // Start re-pulsed mid-run must be ignored; the following start is accepted.
    run_vec('{"ignore_start", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 1'b1,
              32'h42000000}, 5);
    run_vec('{"after_ignore", 32'h40000000, 32'h40000000, 32'h40000000, 32'hFFFFFFFF, 1'b1,
              32'h42800000}, -10);

    // Asynchronous reset mid-accumulation.
    @(negedge clk);
    set_data(32'h3F800000, 32'h3F800000, 32'h3F800000);
    mask = 32'hFFFF_FFFF;
    cru  = 2'b11;
    @(posedge clk);
    #1 cru = 2'b00;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("midrst_sum", sum, 32'h0);
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Accumulator must have been cleared by reset even without acc_clear.
    run_vec('{"post_reset", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 1'b0,
              32'h42000000}, -10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
